// File: rtl/queue_fifo_pkg.sv
// queue_fifo_pkg: shared constants and helpers for the queue_fifo block.
//   ptr_width() - pointer width for a given slot count
//   ZeroWord    - all-zero word used to gate out_data while the queue is empty
package queue_fifo_pkg;

    // Widest word the zero-gate constant covers; queue_fifo slices it to W.
    localparam int unsigned MaxWordW = 1024;
    localparam logic [MaxWordW-1:0] ZeroWord = '0;

    // Pointer width; clamped to 1 so a degenerate depth still gives a legal vector.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/queue_fifo_slot.sv
// queue_slot: one W-bit storage register with write enable. Not reset; the
// pointer/count logic in queue_fifo guarantees unwritten contents are never shown.
//   clk_i - rising-edge clock
//   we_i  - load d_i on this edge
//   d_i   - word to store
//   q_o   - stored word
module queue_slot #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/queue_fifo.sv
// queue_fifo: registered first-word-fall-through queue between a valid/ready
// producer and consumer. Owns DEPTH storage slots, read/write pointers and count.
//   clk       - rising-edge clock
//   reset     - synchronous, active-high reset (pointers and count only)
//   in_valid  - producer offers in_data
//   in_data   - word to enqueue
//   in_ready  - queue accepts a word this cycle
//   out_valid - out_data holds the oldest stored word
//   out_data  - oldest word, zero when out_valid is low
//   out_ready - consumer takes out_data this cycle
//   count     - words stored, 0..DEPTH
module queue_fifo
    import queue_fifo_pkg::*;
#(
    parameter  int unsigned W     = 16,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          push, pop;
    logic [W-1:0]  slot_q [DEPTH];
    logic [W-1:0]  rd_word;

    // Handshake: both flags derive from registered count; reset masks them so
    // nothing is offered or accepted while the queue is being cleared.
    assign in_ready  = (count_q != FullCount) & ~reset;
    assign out_valid = (count_q != '0) & ~reset;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        queue_slot #(
            .W (W)
        ) u_slot (
            .clk_i (clk),
            .we_i  (push && (wr_ptr_q == AW'(i))),
            .d_i   (in_data),
            .q_o   (slot_q[i])
        );
    end

    always_comb begin
        rd_word = slot_q[rd_ptr_q];
    end

    // Zero gate keeps never-written slot contents off the downstream datapath.
    assign out_data = out_valid ? rd_word : ZeroWord[W-1:0];
    assign count    = count_q;

    // DEPTH is a power of two, so natural AW-bit overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = AW'(wr_ptr_q + 1'b1);
        end
        if (pop) begin
            rd_ptr_d = AW'(rd_ptr_q + 1'b1);
        end
        unique case ({push, pop})
            2'b10:   count_d = (AW + 1)'(count_q + 1'b1);
            2'b01:   count_d = (AW + 1)'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_queue_fifo.sv
// tb_queue_fifo: directed self-checking bench for queue_fifo (W=16, DEPTH=4).
module tb_queue_fifo;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [2:0]    count;

    int unsigned   total_cnt = 0;
    int unsigned   pass_cnt  = 0;

    queue_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".count"},     32'(count),     32'd0);
        check({tag, ".out_data"},  32'(out_data),  32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset then idle
        step();
        check("rst.in_ready",  32'(in_ready),  32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.count",     32'(count),     32'd0);
        check("rst.out_data",  32'(out_data),  32'h0);
        reset = 1'b0;
        #1;
        check_idle("idle0");
        step();
        check_idle("idle1");
        step();
        check_idle("idle2");

        // Fill to full, head stays A001
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hA001 + 16'(i);
            step();
            check("fill.count",    32'(count),     32'(i + 1));
            check("fill.head",     32'(out_data),  32'hA001);
            check("fill.out_valid", 32'(out_valid), 32'd1);
        end
        check("full.in_ready", 32'(in_ready), 32'd0);
        in_data = 16'hA005;
        step();
        check("refuse.count", 32'(count),    32'd4);
        check("refuse.head",  32'(out_data), 32'hA001);
        in_valid = 1'b0;

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain.data", 32'(out_data), 32'hA001 + 32'(i));
            step();
            check("drain.in_ready", 32'(in_ready), 32'd1);
            check("drain.count",    32'(count),    32'(3 - i));
        end
        check("drained.out_valid", 32'(out_valid), 32'd0);
        check("drained.out_data",  32'(out_data),  32'h0);
        out_ready = 1'b0;

        // Sustained push+pop at count=2, pointers wrap
        in_valid = 1'b1;
        in_data  = 16'hB000;
        step();
        in_data  = 16'hB001;
        step();
        check("stream.pre_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 16'hB002 + 16'(k);
            check("stream.data", 32'(out_data), 32'hB000 + 32'(k));
            step();
            check("stream.count", 32'(count), 32'd2);
        end
        check("stream.head", 32'(out_data), 32'hB00A);

        // Full with push and pop both offered: only the pop happens
        out_ready = 1'b0;
        in_data   = 16'hB00C;
        step();
        in_data   = 16'hB00D;
        step();
        check("full2.count",    32'(count),    32'd4);
        in_data   = 16'hB00E;
        out_ready = 1'b1;
        #1;
        check("full2.in_ready", 32'(in_ready), 32'd0);
        step();
        check("fullpop.count",    32'(count),    32'd3);
        check("fullpop.in_ready", 32'(in_ready), 32'd1);
        check("fullpop.head",     32'(out_data), 32'hB00B);
        out_ready = 1'b0;
        step();
        check("refill.count", 32'(count), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("refill.data", 32'(out_data), 32'hB00B + 32'(i));
            step();
        end
        check("refill.empty", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Reset mid-operation with count=3 and in_valid held
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'hD001 + 16'(i);
            step();
        end
        check("pre_rst.count", 32'(count), 32'd3);
        reset   = 1'b1;
        in_data = 16'hDEAD;
        #1;
        check("in_rst.in_ready",  32'(in_ready),  32'd0);
        check("in_rst.out_valid", 32'(out_valid), 32'd0);
        step();
        check("post_rst.count",     32'(count),     32'd0);
        check("post_rst.out_valid", 32'(out_valid), 32'd0);
        check("post_rst.out_data",  32'(out_data),  32'h0);
        step();
        check("hold_rst.count", 32'(count), 32'd0);
        reset   = 1'b0;
        in_data = 16'hC0DE;
        #1;
        check("rel.in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("c0de.out_valid", 32'(out_valid), 32'd1);
        check("c0de.out_data",  32'(out_data),  32'hC0DE);
        check("c0de.count",     32'(count),     32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("final.count",    32'(count),    32'd0);
        check("final.out_data", 32'(out_data), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
